// File: rtl/hasti_io_bridge_if.sv
// HASTI (AHB-Lite) slave-side signal bundle for the I/O bridge.
// Modport f is the slave view: requests come in, the response goes out.
interface if_hasti_slave_io;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport f (
    input  hsel, haddr, hwrite, hsize, htrans, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/hasti_io_bridge.sv
// HASTI slave that turns each transfer into one SETUP/ACCESS peripheral access,
// stalling until pready and answering ERROR on slave error, timeout or misalignment.
module hasti_io_bridge #(
  parameter int PADDR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               hclk,
  input  logic               hresetn,
  if_hasti_slave_io.f        s,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [PADDR_W-1:0] paddr,
  output logic [31:0]        pwdata,
  output logic [3:0]         pstrb,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_pwrite;
  logic [PADDR_W-1:0] r_paddr;
  logic [31:0]        r_pwdata;
  logic [3:0]         r_pstrb;
  logic [31:0]        r_hrdata;

  logic               w_req;
  logic               w_aligned;
  logic [3:0]         w_strb;
  logic               w_accept;
  logic               w_rd_load;
  logic               w_timeout;
  logic               w_unused_haddr;

  assign w_unused_haddr = ^s.haddr[31:PADDR_W];

  assign w_req     = s.hsel & s.hready & s.htrans[1];
  assign w_timeout = (TIMEOUT > 0) && !pready && (r_cnt == CNT_LAST);

  always_comb begin
    w_aligned = 1'b0;
    case (s.hsize)
      3'd0:    w_aligned = 1'b1;
      3'd1:    w_aligned = !s.haddr[0];
      3'd2:    w_aligned = (s.haddr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  always_comb begin
    w_strb = 4'b1111;
    case (s.hsize[1:0])
      2'd0:    w_strb = 4'b0001 << s.haddr[1:0];
      2'd1:    w_strb = 4'b0011 << s.haddr[1:0];
      default: w_strb = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ERR2 accepts a new request exactly like IDLE so back-to-back transfers survive an error.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_rd_load    = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_next = ST_IDLE;
        if (w_req) begin
          if (w_aligned) begin
            w_state_next = ST_SETUP;
            w_accept     = 1'b1;
          end else begin
            w_state_next = ST_ERR1;
          end
        end
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
        w_cnt_next   = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_state_next = pslverr ? ST_ERR1 : ST_IDLE;
          w_rd_load    = !pslverr && !r_pwrite;
        end else if (w_timeout) begin
          w_state_next = ST_ERR1;
        end else if (r_cnt != CNT_LAST) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_ERR1: begin
        w_state_next = ST_ERR2;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_hrdata <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= s.haddr[PADDR_W-1:0];
        r_pwrite <= s.hwrite;
        r_pstrb  <= s.hwrite ? w_strb : 4'b0000;
      end
      if (r_state == ST_SETUP) begin
        r_pwdata <= s.hwdata;
      end
      if (w_rd_load) begin
        r_hrdata <= prdata;
      end
    end
  end

  // Bus handshakes are decoded straight from state so reset drops them immediately.
  assign psel        = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable     = (r_state == ST_ACCESS);
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign s.hrdata    = r_hrdata;
  assign s.hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign s.hresp     = (r_state == ST_ERR1) || (r_state == ST_ERR2);

endmodule

// File: tb/tb_hasti_io_bridge.sv
// Randomized scoreboard bench for hasti_io_bridge: a transaction-level model predicts
// each response and peripheral access; bus and peripheral monitors pop and compare.
module tb_hasti_io_bridge;
  localparam int TO = 4;

  typedef struct {
    bit          hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    bit          hwrite;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    bit          resp;
    int          low;
    logic [31:0] hrdata;
    int          id;
  } exp_t;

  typedef struct {
    logic [15:0] paddr;
    bit          write;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    logic [31:0] rdata;
    int          id;
  } plan_t;

  logic        hclk;
  logic        hresetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  if_hasti_slave_io bus();
  assign bus.hready = bus.hreadyout;

  hasti_io_bridge #(.PADDR_W(16), .TIMEOUT(TO)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .s       (bus),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  int          checks = 0;
  int          failures = 0;
  int          n_issued = 0;
  logic [31:0] model_hrdata = 32'h0;
  exp_t        sb_q[$];
  plan_t       plan_q[$];
  txn_t        stim_q[$];

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d actual=0x%0h required=0x%0h", name, id, act, exp);
    end
  endtask

  function automatic txn_t mk(bit hsel, logic [1:0] htrans, logic [2:0] hsize, logic [31:0] addr,
                              bit wr, logic [31:0] wd, int waits, bit err, logic [31:0] rd);
    txn_t t;
    t.hsel = hsel; t.htrans = htrans; t.hsize = hsize; t.haddr = addr;
    t.hwrite = wr; t.wdata = wd; t.waits = waits; t.err = err; t.rdata = rd;
    return t;
  endfunction

  task automatic rand_txn(output txn_t t);
    int r;
    int lo;
    t.hsel = ($urandom_range(0, 9) != 0);
    r = $urandom_range(0, 11);
    t.htrans = (r < 7) ? 2'd2 : (r < 9) ? 2'd3 : (r == 9) ? 2'd1 : 2'd0;
    t.hsize = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    lo = $urandom_range(0, 3);
    if ($urandom_range(0, 5) != 0 && t.hsize <= 3'd2) lo = lo & ~((1 << int'(t.hsize)) - 1);
    t.haddr = 32'h8000_0000 | ($urandom() & 32'h7fff_fffc) | 32'(lo);
    t.hwrite = $urandom_range(0, 1) == 1;
    t.wdata = $urandom();
    t.waits = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(4, 8);
    t.err = ($urandom_range(0, 5) == 0);
    t.rdata = $urandom();
  endtask

  task automatic drive_addr(input txn_t t);
    bus.hsel = t.hsel; bus.haddr = t.haddr; bus.hwrite = t.hwrite;
    bus.hsize = t.hsize; bus.htrans = t.htrans;
  endtask

  task automatic drive_idle();
    bus.hsel = 1'b0; bus.htrans = 2'd0; bus.haddr = 32'h0; bus.hwrite = 1'b0; bus.hsize = 3'd0;
  endtask

  // Reference model: predicts response, wait states and the peripheral access for one accepted address phase.
  task automatic issue(input txn_t t);
    exp_t  e;
    plan_t p;
    bit    aligned;
    int    nbytes;
    int    mask;
    bus.hwdata = t.wdata;
    e.id = n_issued;
    if (!(t.hsel && t.htrans[1])) begin
      e.resp = 1'b0; e.low = 0;
    end else begin
      aligned = (t.hsize == 3'd0) || (t.hsize == 3'd1 && !t.haddr[0]) ||
                (t.hsize == 3'd2 && t.haddr[1:0] == 2'b00);
      if (!aligned) begin
        e.resp = 1'b1; e.low = 1;
      end else begin
        nbytes = 1 << int'(t.hsize);
        mask = (1 << nbytes) - 1;
        p.paddr = t.haddr[15:0];
        p.write = t.hwrite;
        p.strb = t.hwrite ? 4'((mask << int'(t.haddr[1:0])) & 15) : 4'h0;
        p.wdata = t.wdata; p.waits = t.waits; p.err = t.err; p.rdata = t.rdata; p.id = n_issued;
        plan_q.push_back(p);
        if (t.waits >= TO) begin
          e.resp = 1'b1; e.low = TO + 2;
        end else if (t.err) begin
          e.resp = 1'b1; e.low = t.waits + 3;
        end else begin
          e.resp = 1'b0; e.low = t.waits + 2;
          if (!t.hwrite) model_hrdata = t.rdata;
        end
      end
    end
    e.hrdata = model_hrdata;
    sb_q.push_back(e);
    n_issued++;
  endtask

  // Pipelined master: the next address phase is driven as soon as the previous one is accepted.
  task automatic run(input int n_txn);
    txn_t a;
    bit   hr;
    int   accepted = 0;
    int   guard = 0;
    if (stim_q.size() > 0) a = stim_q.pop_front(); else rand_txn(a);
    drive_addr(a);
    while (accepted < n_txn && guard < 20000) begin
      @(negedge hclk);
      hr = bus.hreadyout;
      @(posedge hclk);
      #1;
      guard++;
      if (hr) begin
        issue(a);
        accepted++;
        if (accepted < n_txn) begin
          if (stim_q.size() > 0) a = stim_q.pop_front(); else rand_txn(a);
          drive_addr(a);
        end else begin
          drive_idle();
        end
      end
    end
    check("run_accepted", -1, 32'(accepted), 32'(n_txn));
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() > 0 && g < 200) begin
      @(posedge hclk);
      #1;
      g++;
    end
    check("drain_sb_empty", -1, 32'(sb_q.size()), 32'd0);
  endtask

  // Bus monitor: counts stall cycles and compares the completed data phase with the head of the scoreboard.
  initial begin : bus_monitor
    exp_t e;
    int   low;
    logic exp_r;
    low = 0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        low = 0;
      end else if (sb_q.size() > 0) begin
        e = sb_q[0];
        if (!bus.hreadyout) begin
          exp_r = e.resp && (low == e.low - 1);
          check("hresp_stall", e.id, 32'(bus.hresp), 32'(exp_r));
          low++;
        end else begin
          void'(sb_q.pop_front());
          check("wait_states", e.id, 32'(low), 32'(e.low));
          check("hresp", e.id, 32'(bus.hresp), 32'(e.resp));
          check("hrdata", e.id, bus.hrdata, e.hrdata);
          low = 0;
        end
      end
    end
  end

  // Peripheral model: replays the planned answer and checks the SETUP/ACCESS fields.
  initial begin : periph
    plan_t cur;
    bit    have;
    bit    first;
    int    cnt;
    have = 1'b0; first = 1'b0; cnt = 0;
    pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        have = 1'b0; pready = 1'b0;
      end else if (psel && !penable) begin
        check("plan_avail", -1, 32'(plan_q.size() > 0), 32'd1);
        have = (plan_q.size() > 0);
        if (have) begin
          cur = plan_q.pop_front();
          check("paddr", cur.id, 32'(paddr), 32'(cur.paddr));
          check("pwrite", cur.id, 32'(pwrite), 32'(cur.write));
          check("pstrb", cur.id, 32'(pstrb), 32'(cur.strb));
        end
        cnt = 0; first = 1'b1;
        pready = 1'($urandom); prdata = $urandom(); pslverr = 1'($urandom);
      end else if (psel && penable) begin
        if (first && have && cur.write) check("pwdata", cur.id, pwdata, cur.wdata);
        first = 1'b0;
        if (have && cnt == cur.waits) begin
          pready = 1'b1; prdata = cur.rdata; pslverr = cur.err;
        end else begin
          pready = 1'b0; prdata = $urandom(); pslverr = 1'($urandom);
        end
        cnt++;
      end else begin
        pready = 1'($urandom); prdata = $urandom(); pslverr = 1'($urandom);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hreadyout"}, -1, 32'(bus.hreadyout), 32'd1);
    check({tag, "_hresp"}, -1, 32'(bus.hresp), 32'd0);
    check({tag, "_hrdata"}, -1, bus.hrdata, 32'd0);
    check({tag, "_psel"}, -1, 32'(psel), 32'd0);
    check({tag, "_penable"}, -1, 32'(penable), 32'd0);
    check({tag, "_pwrite"}, -1, 32'(pwrite), 32'd0);
    check({tag, "_paddr"}, -1, 32'(paddr), 32'd0);
    check({tag, "_pwdata"}, -1, pwdata, 32'd0);
    check({tag, "_pstrb"}, -1, 32'(pstrb), 32'd0);
  endtask

  initial begin : main
    plan_t p;
    int    g;
    hresetn = 1'b0;
    drive_idle();
    bus.hwdata = 32'h0;
    repeat (3) @(posedge hclk);
    #1;
    check_reset_outputs("reset");
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    stim_q.push_back(mk(1, 2'd2, 3'd2, 32'h8000_0010, 1, 32'hdeadbeef, 0, 0, 32'h0));
    stim_q.push_back(mk(1, 2'd2, 3'd0, 32'h8000_0003, 0, 32'h0, 3, 0, 32'h12345678));
    stim_q.push_back(mk(1, 2'd2, 3'd1, 32'h8000_0001, 1, 32'h5555aaaa, 0, 0, 32'h0));
    stim_q.push_back(mk(1, 2'd2, 3'd2, 32'h8000_0020, 0, 32'h0, 0, 0, 32'hcafef00d));
    stim_q.push_back(mk(1, 2'd2, 3'd2, 32'h8000_0024, 0, 32'h0, 100, 0, 32'h11111111));
    stim_q.push_back(mk(1, 2'd2, 3'd2, 32'h8000_0028, 0, 32'h0, 1, 1, 32'h22222222));
    stim_q.push_back(mk(1, 2'd0, 3'd2, 32'h8000_0030, 0, 32'h0, 0, 0, 32'h0));
    stim_q.push_back(mk(0, 2'd2, 3'd2, 32'h8000_0034, 1, 32'h0, 0, 0, 32'h0));
    stim_q.push_back(mk(1, 2'd2, 3'd3, 32'h8000_0040, 1, 32'h0, 0, 0, 32'h0));
    run(9 + 300);
    drain();

    // Reset in the middle of a stalled ACCESS: transfer is dropped, outputs return to reset values at once.
    p.paddr = 16'h0040; p.write = 1'b0; p.strb = 4'h0; p.wdata = 32'h0;
    p.waits = 1000; p.err = 1'b0; p.rdata = 32'h0; p.id = -2;
    plan_q.push_back(p);
    drive_addr(mk(1, 2'd2, 3'd2, 32'h8000_0040, 0, 32'h0, 1000, 0, 32'h0));
    bus.hwdata = $urandom();
    @(posedge hclk);
    #1;
    drive_idle();
    g = 0;
    while (!penable && g < 10) begin
      @(posedge hclk);
      #1;
      g++;
    end
    check("reach_access", -2, 32'(penable), 32'd1);
    @(posedge hclk);
    #3;
    hresetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb_q.delete();
    plan_q.delete();
    model_hrdata = 32'h0;
    @(negedge hclk);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    stim_q.push_back(mk(1, 2'd0, 3'd2, 32'h8000_0050, 0, 32'h0, 0, 0, 32'h0));
    stim_q.push_back(mk(1, 2'd2, 3'd2, 32'h8000_0054, 0, 32'h0, 0, 0, 32'h0badf00d));
    run(2 + 30);
    drain();
    check("plan_empty", -1, 32'(plan_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
